// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the NTT result collector.
//   state_e         - collector FSM states
//   depth_legal     - ring_depth legality check against the build's MAX_DEPTH
//   interleave_addr - maps beat number m to its natural-order index for a
//                     core that emits even indices and odd indices interleaved
package ntt_pkg;

  // Widest address the helpers handle; ring_depth is 4 bits, so 15 suffices.
  localparam int unsigned ADDR_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  function automatic logic depth_legal(input logic [3:0] depth,
                                       input int unsigned max_depth);
    return (depth != 4'd0) && (32'(depth) <= max_depth);
  endfunction

  // Beat m goes to m>>1 when even, (m>>1)+N/2 when odd. Since m < N,
  // m>>1 < N/2, so OR-ing in the half-ring bit is the same as adding it.
  function automatic logic [ADDR_MAX_W-1:0] interleave_addr(
      input logic [ADDR_MAX_W-1:0] m,
      input logic [3:0]            depth);
    logic [ADDR_MAX_W-1:0] half;
    half = '0;
    if (depth != 4'd0) half = ADDR_MAX_W'(1) << (depth - 4'd1);
    return m[0] ? ((m >> 1) | half) : (m >> 1);
  endfunction

endpackage

// File: rtl/ntt_coeff_ram.sv
// ntt_coeff_ram: simple dual-port coefficient buffer, 1 write / 1 read,
// synchronous read with one cycle latency, no reset on the array.
//   clk       - clock
//   we_i      - write enable
//   waddr_i   - write address
//   wdata_i   - write data
//   re_i      - read enable; rdata_o updates on the next edge
//   raddr_i   - read address
//   rdata_o   - registered read data
module ntt_coeff_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ntt_result_collector.sv
// ntt_result_collector: captures one ring of NTT output coefficients,
// de-interleaves them if required, applies the final conditional subtraction
// of q, then replays the ring in natural order on a valid/ready stream with
// optional comparison against an expected stream.
//   clk, reset           - clock, synchronous active-high reset
//   start                - pulse: latch ring_depth/q/mode/chk_en, begin capture
//   ring_depth, q        - log2 N and modulus for the run
//   mode                 - 0 natural input order, 1 even/odd interleaved
//   chk_en               - compare drained words with exp_data
//   in_valid, in_data    - coefficient beats from the core
//   out_valid/ready/data - drained stream; out_index/out_last qualify it
//   exp_data             - expected word, sampled on each output handshake
//   err_count            - saturating mismatch count for the current run
//   range_err, extra_err - sticky input-range and late-beat flags
//   cfg_err              - pulse on start with illegal ring_depth
//   busy, done           - run in progress; pulse after the final handshake
module ntt_result_collector
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_DEPTH = 10,
  parameter int unsigned CNT_W     = MAX_DEPTH + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           ring_depth,
  input  logic [DATA_W-1:0]    q,
  input  logic                 mode,
  input  logic                 chk_en,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [MAX_DEPTH-1:0] out_index,
  output logic                 out_last,
  input  logic [DATA_W-1:0]    exp_data,
  output logic [CNT_W-1:0]     err_count,
  output logic                 range_err,
  output logic                 extra_err,
  output logic                 cfg_err,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW = MAX_DEPTH;

  state_e state_q, state_d;

  // Latched run configuration
  logic [3:0]        depth_q;
  logic [DATA_W-1:0] q_q;
  logic              mode_q;
  logic              chk_q;
  logic [AW-1:0]     last_idx_q;

  // Capture / read-side counters
  logic [AW-1:0] m_q;
  logic [AW-1:0] rd_ptr_q;
  logic          rd_done_q;

  // RAM read pipeline stage
  logic          rv_q;
  logic [AW-1:0] rv_idx_q;

  // 2-entry output queue; entry 0 is always the presented word
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] f0_data_q, f1_data_q;
  logic [AW-1:0]     f0_idx_q, f1_idx_q;

  logic [CNT_W-1:0] err_q;
  logic             range_q, extra_q, cfg_err_q, done_q;

  logic              start_ok, start_bad;
  logic              beat, hs, last_hs, issue, flush;
  logic [DATA_W-1:0] red;
  logic              x_ge_2q;
  logic [AW-1:0]     wr_addr;
  logic [2:0]        occ;
  logic [DATA_W-1:0] ram_rdata;

  assign start_ok  = start && depth_legal(ring_depth, MAX_DEPTH);
  assign start_bad = start && !start_ok;

  // r = x - q when x >= q, at DATA_W bits. The 2q range check uses one extra
  // bit because 2q can exceed the bus width even when q itself does not.
  assign red     = (in_data >= q_q) ? (in_data - q_q) : in_data;
  assign x_ge_2q = {1'b0, in_data} >= {q_q, 1'b0};

  assign beat    = (state_q == ST_CAPTURE) && in_valid && !start;
  assign wr_addr = mode_q ? AW'(interleave_addr(ADDR_MAX_W'(m_q), depth_q)) : m_q;

  assign out_valid = (cnt_q != 2'd0);
  assign hs        = out_valid && out_ready;
  assign last_hs   = hs && (f0_idx_q == last_idx_q);

  // Issue a read only if the word it returns is guaranteed a queue slot:
  // current entries plus the word already in flight, less this cycle's pop.
  assign occ   = 3'(cnt_q) + 3'(rv_q);
  assign issue = (state_q == ST_DRAIN) && !rd_done_q && !start &&
                 (occ <= (3'd1 + 3'(hs)));

  assign flush = start || last_hs;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = start_ok ? ST_CAPTURE : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_CAPTURE: if (beat && (m_q == last_idx_q)) state_d = ST_DRAIN;
        ST_DRAIN:   if (last_hs) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q    <= '0;
      q_q        <= '0;
      mode_q     <= 1'b0;
      chk_q      <= 1'b0;
      last_idx_q <= '0;
      m_q        <= '0;
      rd_ptr_q   <= '0;
      rd_done_q  <= 1'b0;
      err_q      <= '0;
      range_q    <= 1'b0;
      extra_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cfg_err_q <= start_bad;
      done_q    <= last_hs && !start;
      if (start_ok) begin
        depth_q    <= ring_depth;
        q_q        <= q;
        mode_q     <= mode;
        chk_q      <= chk_en;
        last_idx_q <= AW'((32'd1 << ring_depth) - 32'd1);
        m_q        <= '0;
        rd_ptr_q   <= '0;
        rd_done_q  <= 1'b0;
        err_q      <= '0;
        range_q    <= 1'b0;
        extra_q    <= 1'b0;
      end else if (!start) begin
        if (beat) begin
          m_q <= m_q + AW'(1);
          if (x_ge_2q) range_q <= 1'b1;
        end
        if ((state_q == ST_DRAIN) && in_valid) extra_q <= 1'b1;
        if (issue) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          if (rd_ptr_q == last_idx_q) rd_done_q <= 1'b1;
        end
        if (hs && chk_q && (f0_data_q != exp_data) && (err_q != '1))
          err_q <= err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q      <= 1'b0;
      rv_idx_q  <= '0;
      cnt_q     <= '0;
      f0_data_q <= '0;
      f0_idx_q  <= '0;
      f1_data_q <= '0;
      f1_idx_q  <= '0;
    end else if (flush) begin
      rv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      rv_q     <= issue;
      rv_idx_q <= rd_ptr_q;
      unique case ({rv_q, hs})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            f0_data_q <= ram_rdata;
            f0_idx_q  <= rv_idx_q;
          end else begin
            f1_data_q <= ram_rdata;
            f1_idx_q  <= rv_idx_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          f0_data_q <= f1_data_q;
          f0_idx_q  <= f1_idx_q;
          cnt_q     <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            f0_data_q <= ram_rdata;
            f0_idx_q  <= rv_idx_q;
          end else begin
            f0_data_q <= f1_data_q;
            f0_idx_q  <= f1_idx_q;
            f1_data_q <= ram_rdata;
            f1_idx_q  <= rv_idx_q;
          end
        end
        default: ;
      endcase
    end
  end

  ntt_coeff_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (beat),
    .waddr_i (wr_addr),
    .wdata_i (red),
    .re_i    (issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign out_data  = f0_data_q;
  assign out_index = f0_idx_q;
  assign out_last  = out_valid && (f0_idx_q == last_idx_q);
  assign err_count = err_q;
  assign range_err = range_q;
  assign extra_err = extra_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ntt_result_collector.sv
module tb_ntt_result_collector;

  localparam int DW = 32;
  localparam int MD = 10;
  localparam int CW = MD + 1;

  logic          clk = 1'b0;
  logic          reset, start, mode, chk_en, in_valid, out_ready;
  logic [3:0]    ring_depth;
  logic [DW-1:0] q, in_data, exp_data, out_data;
  logic          out_valid, out_last, range_err, extra_err, cfg_err, busy, done;
  logic [MD-1:0] out_index;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  ntt_result_collector #(
    .DATA_W    (DW),
    .MAX_DEPTH (MD),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ring_depth (ring_depth),
    .q          (q),
    .mode       (mode),
    .chk_en     (chk_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .exp_data   (exp_data),
    .err_count  (err_count),
    .range_err  (range_err),
    .extra_err  (extra_err),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .done       (done)
  );

  int nvec = 0;
  int nmis = 0;

  logic [DW-1:0] xin  [1024];
  logic [DW-1:0] expv [1024];
  logic [DW-1:0] expd [1024];

  typedef struct {
    logic          mode;
    logic [DW-1:0] q;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic          rerr;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic do_start(input logic [3:0] d, input logic md, input logic [DW-1:0] qq,
                          input logic ce);
    @(negedge clk);
    start = 1'b1; ring_depth = d; mode = md; q = qq; chk_en = ce; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // First beat is driven at the negedge do_start returns on.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1;
      in_data  = xin[i];
    end
  endtask

  // Cycle 1 is the negedge after the last capture beat was driven.
  task automatic drain(input int n, input int pct, input logic inject,
                       output int done_cyc, output int first_cyc);
    int            got, cyc, dones, limit;
    logic          stalled;
    logic [DW-1:0] hd;
    logic [MD-1:0] hi;
    got = 0; cyc = 0; dones = 0; stalled = 1'b0; hd = '0; hi = '0;
    done_cyc = -1; first_cyc = -1; limit = n * 8 + 40;
    while (cyc < limit && !(got == n && dones > 0)) begin
      @(negedge clk);
      cyc++;
      in_valid = inject && (cyc == 4);
      if (done) begin dones++; done_cyc = cyc; end
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(hd));
        chk("stall_index", 64'(out_index), 64'(hi));
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      out_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < pct);
      exp_data = (got < n) ? expd[got] : '0;
      if (out_valid && out_ready) begin
        if (got < n) begin
          chk("out_index", 64'(out_index), 64'(got));
          chk("out_data", 64'(out_data), 64'(expv[got]));
          chk("out_last", 64'(out_last), 64'(got == n - 1));
        end else begin
          chk("word_count", 64'(got + 1), 64'(n));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      hd = out_data;
      hi = out_index;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("words_drained", 64'(got), 64'(n));
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("done_pulses", 64'(dones), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, fc;
    reset = 1'b1; start = 1'b0; ring_depth = '0; q = '0; mode = 1'b0; chk_en = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; exp_data = '0;

    vt[0] = '{1'b0, 32'd7, 32'd3, 32'd10, 32'd3, 32'd3, 1'b0};
    vt[1] = '{1'b0, 32'd7, 32'd7, 32'd13, 32'd0, 32'd6, 1'b0};
    vt[2] = '{1'b0, 32'd7, 32'd14, 32'd0, 32'd7, 32'd0, 1'b1};
    vt[3] = '{1'b1, 32'd7, 32'd1, 32'd2, 32'd1, 32'd2, 1'b0};
    vt[4] = '{1'b0, 32'd100, 32'd205, 32'd99, 32'd105, 32'd99, 1'b1};
    vt[5] = '{1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFE, 32'h8000_0000, 1'b0};
    vt[6] = '{1'b0, 32'd0, 32'd5, 32'd0, 32'd5, 32'd0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_index", 64'(out_index), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_range_err", 64'(range_err), 64'(0));
    chk("rst_extra_err", 64'(extra_err), 64'(0));
    chk("rst_cfg_err", 64'(cfg_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset = 1'b0;

    // Two-word rings exercising the reduction boundaries.
    for (int v = 0; v < 7; v++) begin
      xin[0] = vt[v].x0; xin[1] = vt[v].x1;
      expv[0] = vt[v].e0; expv[1] = vt[v].e1;
      expd[0] = vt[v].e0; expd[1] = vt[v].e1;
      do_start(4'd1, vt[v].mode, vt[v].q, 1'b1);
      capture(2);
      drain(2, 100, 1'b0, dc, fc);
      chk("vec_range_err", 64'(range_err), 64'(vt[v].rerr));
      chk("vec_err_count", 64'(err_count), 64'(0));
    end

    // Natural order, N=256, with latency measurement.
    for (int i = 0; i < 256; i++) begin
      xin[i]  = (i % 2 == 0) ? DW'(i + 7681) : DW'(i);
      expv[i] = DW'(i);
      expd[i] = DW'(i);
    end
    do_start(4'd8, 1'b0, 32'd7681, 1'b0);
    capture(256);
    drain(256, 100, 1'b0, dc, fc);
    chk("nat_done_latency", 64'(dc), 64'(259));
    chk("nat_first_valid", 64'(fc), 64'(3));
    chk("nat_err_count", 64'(err_count), 64'(0));
    chk("nat_busy_after", 64'(busy), 64'(0));

    // Interleaved input order, N=256.
    for (int m = 0; m < 256; m++) begin
      xin[m]  = DW'(m);
      expv[m] = (m < 128) ? DW'(2 * m) : DW'(2 * (m - 128) + 1);
      expd[m] = expv[m];
    end
    do_start(4'd8, 1'b1, 32'd7681, 1'b1);
    capture(256);
    drain(256, 100, 1'b0, dc, fc);
    chk("ilv_err_count", 64'(err_count), 64'(0));

    // N=1024 with 50% random backpressure and checking enabled.
    for (int i = 0; i < 1024; i++) begin
      xin[i]  = DW'($urandom_range(2 * 12289 - 1));
      expv[i] = (xin[i] >= 32'd12289) ? xin[i] - 32'd12289 : xin[i];
      expd[i] = expv[i];
    end
    do_start(4'd10, 1'b0, 32'd12289, 1'b1);
    capture(1024);
    drain(1024, 50, 1'b0, dc, fc);
    chk("rnd_err_count", 64'(err_count), 64'(0));
    chk("rnd_range_err", 64'(range_err), 64'(0));

    // Expected stream with three corrupted words.
    for (int i = 0; i < 16; i++) begin
      xin[i]  = DW'((i * 13) % 194);
      expv[i] = (xin[i] >= 32'd97) ? xin[i] - 32'd97 : xin[i];
      expd[i] = expv[i];
    end
    expd[0]  = expd[0] ^ 32'd1;
    expd[7]  = expd[7] ^ 32'd4;
    expd[15] = expd[15] ^ 32'h8000_0000;
    do_start(4'd4, 1'b0, 32'd97, 1'b1);
    capture(16);
    drain(16, 70, 1'b0, dc, fc);
    chk("corrupt_err_count", 64'(err_count), 64'(3));

    // Out-of-range input and a stray beat during drain.
    xin[0] = 32'd205; xin[1] = 32'd1; xin[2] = 32'd2; xin[3] = 32'd3;
    expv[0] = 32'd105; expv[1] = 32'd1; expv[2] = 32'd2; expv[3] = 32'd3;
    for (int i = 0; i < 4; i++) expd[i] = expv[i];
    do_start(4'd2, 1'b0, 32'd100, 1'b0);
    capture(4);
    drain(4, 100, 1'b1, dc, fc);
    chk("range_err_set", 64'(range_err), 64'(1));
    chk("extra_err_set", 64'(extra_err), 64'(1));

    // Illegal ring_depth values.
    do_start(4'd11, 1'b0, 32'd100, 1'b0);
    chk("cfg11_pulse", 64'(cfg_err), 64'(1));
    chk("cfg11_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("cfg11_pulse_end", 64'(cfg_err), 64'(0));
    do_start(4'd0, 1'b0, 32'd100, 1'b0);
    chk("cfg0_pulse", 64'(cfg_err), 64'(1));
    chk("cfg0_busy", 64'(busy), 64'(0));

    // Restart in the middle of capture.
    for (int i = 0; i < 8; i++) xin[i] = DW'(i + 40);
    do_start(4'd3, 1'b0, 32'd50, 1'b0);
    capture(3);
    xin[0] = 32'd60; xin[1] = 32'd1; xin[2] = 32'd2; xin[3] = 32'd99;
    expv[0] = 32'd10; expv[1] = 32'd1; expv[2] = 32'd2; expv[3] = 32'd49;
    for (int i = 0; i < 4; i++) expd[i] = expv[i];
    do_start(4'd2, 1'b0, 32'd50, 1'b0);
    chk("abort_busy", 64'(busy), 64'(1));
    chk("abort_extra_clr", 64'(extra_err), 64'(0));
    capture(4);
    drain(4, 100, 1'b0, dc, fc);

    // Reset in the middle of drain.
    for (int i = 0; i < 16; i++) xin[i] = DW'(i);
    do_start(4'd4, 1'b0, 32'd1000, 1'b0);
    capture(16);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    reset = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ntt_result_collector.md
# ntt_result_collector

Parametrised result-capture stage between the NTT core output port (`dout0`/`done`) and the host or self-test logic. It takes one coefficient per valid beat and undoes the core's even/odd output interleaving when required, applies the final conditional subtraction of q, and buffers a full ring of up to 2^MAX_DEPTH coefficients. It replays the ring in natural order over a valid/ready stream and can optionally compare it against an expected stream, counting mismatches. It replaces the bench-side `fout` reassembly and check loop with synthesisable logic sized for any ring depth and coefficient width.

## Interface
- `DATA_W`, 32, coefficient/bus width in bits
- `MAX_DEPTH`, 10, log2 of the largest supported ring (buffer = 2^MAX_DEPTH words)
- `CNT_W`, MAX_DEPTH+1, width of the mismatch counter
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; latches `ring_depth`, `q`, `mode`, `chk_en` and arms capture
- `ring_depth`  in  4  log2 N for this run; legal range 1..MAX_DEPTH
- `q`  in  DATA_W  modulus
- `mode`  in  1  0 = natural input order, 1 = interleaved (beat m goes to index m>>1 if m even, (m>>1)+N/2 if odd)
- `chk_en`  in  1  1 = compare drained words against `exp_data`
- `in_valid`  in  1  coefficient beat from the core
- `in_data`  in  DATA_W  raw coefficient, nominally in [0, 2q)
- `out_valid`  out  1  drained word available; reset 0
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  DATA_W  reduced coefficient; reset 0
- `out_index`  out  MAX_DEPTH  natural-order index of `out_data`; reset 0
- `out_last`  out  1  qualifies index N-1; reset 0
- `exp_data`  in  DATA_W  expected value, sampled on each output handshake when `chk_en`=1
- `err_count`  out  CNT_W  mismatches in the current run; reset 0
- `range_err`  out  1  sticky: some input was >= 2q; reset 0
- `extra_err`  out  1  sticky: `in_valid` was seen while in DRAIN; reset 0
- `cfg_err`  out  1  one-cycle pulse when `start` carries an illegal `ring_depth`; reset 0
- `busy`  out  1  high in CAPTURE/DRAIN; reset 0
- `done`  out  1  one-cycle pulse after the last output handshake; reset 0

## Operation
- States: IDLE, CAPTURE, DRAIN. Reset or power-up enters IDLE.
- IDLE:
  - Legal `start`: latch config, clear `err_count`, `range_err`, `extra_err` and the beat counter m, then go to CAPTURE.
  - Illegal `ring_depth` (0 or > MAX_DEPTH): pulse `cfg_err` and stay in IDLE.
  - `in_valid` is ignored.
- CAPTURE, on each `in_valid`:
  - Reduced value is r = (x >= q) ? x - q : x, computed on DATA_W bits without widening.
  - If x >= 2q, set `range_err`; r is still x - q.
  - Write r to the address given by `mode` and m; then m++.
  - The beat with m = N-1 moves the block to DRAIN.
- DRAIN:
  - Read indices 0..N-1 in order.
  - Hold `out_data`, `out_index`, `out_last` stable while `out_valid` & !`out_ready`.
  - Handshake = `out_valid` & `out_ready`. When `chk_en`=1, increment `err_count` on a handshake where `out_data` != `exp_data`. The counter saturates at all-ones.
  - The handshake with `out_last`=1 pulses `done` next cycle and returns to IDLE. `err_count` holds its value until the next legal `start`.
- `in_valid` during DRAIN sets `extra_err`; the data is discarded.
- `start` in CAPTURE/DRAIN aborts the run and restarts with the new config.
  - Illegal `start` there pulses `cfg_err` and returns to IDLE.
  - No `done` is issued for the aborted run.
- `reset` at any time: IDLE, all outputs at reset values, buffer contents not cleared.

## Timing
- Capture accepts one beat per cycle with no backpressure; the write lands in the same cycle as `in_valid`.
- RAM read latency is 1 cycle. First `out_valid` rises 2 cycles after entering DRAIN.
- A 2-entry prefetch/skid register gives 1 word/cycle sustained while `out_ready`=1, with no bubble after `out_ready` deasserts and reasserts.
- Total latency for N words with `out_ready` tied high: last input beat to `done` = N + 3 cycles.
- `start` and the final CAPTURE beat in the same cycle: `start` wins (abort and restart).

## Structure
- Shared package, `ntt_pkg`:
  - state enum
  - `MAX_DEPTH` legality check function
  - interleave address function (m, ring_depth) -> index
- Sub-module `ntt_coeff_ram`:
  - 1 write / 1 read port, synchronous read, depth 2^MAX_DEPTH, width DATA_W
  - inferrable as BRAM, no reset on the array

## Test plan
- Natural order, N=256, q=7681, inputs x_i = i + 7681 for even i and x_i = i for odd i, `out_ready`=1 -> outputs 0..255 with `out_index`=i, `out_last` on 255, `done` 259 cycles after the last input, `err_count`=0.
- Interleaved, N=256, input beat m = m -> output index k carries 2k for k<128 and 2(k-128)+1 for k>=128.
- Random `out_ready` (50%), N=1024, DATA_W=32 -> no word lost, duplicated or changed while stalled.
- `chk_en`=1, expected stream with 3 corrupted words -> `err_count`=3, `done` pulses once.
- Input 2q+5 -> `range_err`=1 and output q+5; extra `in_valid` in DRAIN -> `extra_err`=1.
- `start` with `ring_depth`=11 -> `cfg_err` pulse, stays IDLE. `start` mid-CAPTURE -> restart, no `done`. `reset` mid-DRAIN -> `out_valid`=0 and `busy`=0 the next cycle.
